hazard_unit: RTL and testbench
==============================

Name: hazard_unit

Overview:
- Control-side counterpart of the ID/EX pipeline latch.
- Consumes the latch's EX-stage outputs (dREN, RegWr, wsel, jump/branch resolution) plus ID-stage register selects and cache hit signals.
- Produces the enable/flush inputs for all four pipeline latches and the PC write enable.
- Tracks a data-memory wait state, a terminal halt state, and saturating stall/flush performance counters.

Parameters:
- CNT_W, 16, width of stall_cnt and flush_cnt.

Ports:
- CLK  in  1  system clock, rising edge
- nRST  in  1  asynchronous active-low reset
- ihit  in  1  instruction fetch complete this cycle
- dhit  in  1  data access complete this cycle
- id_rs  in  5  Rs of instruction in ID
- id_rt  in  5  Rt of instruction in ID
- id_uses_rt  in  1  ID instruction reads Rt (R-type, branch, store)
- ex_dREN  in  1  dREN_out of ID/EX latch
- ex_RegWr  in  1  RegWr_out of ID/EX latch
- ex_wsel  in  5  wsel_out of ID/EX latch
- ex_redirect  in  1  EX resolved taken branch or jump (PC loads non-sequential target)
- mem_dREN  in  1  EX/MEM dREN
- mem_dWEN  in  1  EX/MEM dWEN
- wb_halt  in  1  halt present in MEM/WB latch
- pc_en  out  1  PC write enable
- ifid_en, ifid_flush  out  1 each  IF/ID controls
- idex_en, idex_flush  out  1 each  ID/EX controls (drive enable/flush of ID/EX latch)
- exmem_en, exmem_flush  out  1 each  EX/MEM controls
- memwb_en  out  1  MEM/WB enable
- halted  out  1  processor halted
- stall_cnt  out  CNT_W  cycles with pc_en=0 while not halted, saturating
- flush_cnt  out  CNT_W  redirect flush events, saturating

Behaviour:
- Async reset (nRST=0): state=RUN, counters=0. While nRST=0, all enables=0, all flushes=0, halted=0.
- FSM states:
  - RUN→DWAIT when (mem_dREN|mem_dWEN)&!dhit.
  - DWAIT→RUN on dhit.
  - Any state→HALT when wb_halt=1.
  - HALT exits only on reset.
- Control outputs are combinational from state and current inputs; state and counters update on the CLK rising edge. Evaluate in strict priority order, first match wins:
  1. HALT state or wb_halt=1: all en=0, all flush=0. halted=1 (asserted combinationally in the wb_halt cycle, then registered in HALT).
  2. Memory stall, (mem_dREN|mem_dWEN)&!dhit, in RUN or DWAIT: pc_en=ifid_en=idex_en=exmem_en=0, memwb_en=1, exmem_flush=1 so a bubble enters MEM/WB. No other flush.
  3. ex_redirect: pc_en=1, ifid_flush=1, idex_flush=1. All enables=1 and exmem_flush=0 so the branch/jump advances. flush_cnt+1.
  4. Load-use: ex_dREN & ex_RegWr & ex_wsel!=0 & (ex_wsel==id_rs | (id_uses_rt & ex_wsel==id_rt)). Outputs: pc_en=0, ifid_en=0, idex_flush=1, exmem_en=memwb_en=1. Lasts exactly one cycle; the load then leaves EX.
  5. !ihit: pc_en=0, ifid_flush=1, downstream en=1.
  6. Otherwise: all en=1, all flush=0.
- Register 0 never causes a hazard.
- Redirect and load-use are mutually exclusive by construction (one EX instruction); if both are asserted, redirect wins.
- dhit in the same cycle as a pending access: no stall; that cycle falls through to lower priorities.
- Counters:
  - stall_cnt increments each cycle with pc_en=0 and not halted.
  - Both counters saturate at 2^CNT_W-1.
  - Both freeze in HALT.
- Reset mid-stall (DWAIT) or mid-halt returns to RUN next edge after release; counters cleared.

Test Plan:
- Load-use: ex_dREN=1, ex_RegWr=1, ex_wsel=5, id_rs=5, ihit=1 → exactly 1 cycle of pc_en=0, ifid_en=0, idex_flush=1; stall_cnt=1. Next cycle all en=1.
- Rt, $0 and id_uses_rt: ex_wsel=0 with id_rs=0 → no stall. ex_wsel=7, id_rt=7, id_uses_rt=0 → no stall. Same with id_uses_rt=1 → stall.
- Data wait: mem_dREN=1, dhit=0 for 3 cycles, then dhit=1 → 3 cycles of pc/ifid/idex/exmem en=0 with exmem_flush=1 and memwb_en=1; state=DWAIT; 4th cycle all en=1; stall_cnt=3.
- Redirect during I-miss: ex_redirect=1, ihit=0 → pc_en=1, ifid_flush=1, idex_flush=1; flush_cnt=1. Redirect concurrent with dcache miss → memory stall wins, flush_cnt unchanged.
- Halt: wb_halt=1 → same cycle all en=0, halted=1. Stays halted after wb_halt drops and under ex_redirect=1; counters frozen.
- Reset/saturation: nRST low during DWAIT → all en=0 immediately; after release state=RUN, counters=0. Force CNT_W=2, 5 stall cycles → stall_cnt=3.

Source files
------------

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: per-latch enable/flush, PC write enable,
// a data-memory wait state, a terminal halt state and stall/flush counters.
module hazard_unit #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_dREN,
  input  logic             ex_RegWr,
  input  logic [4:0]       ex_wsel,
  input  logic             ex_redirect,
  input  logic             mem_dREN,
  input  logic             mem_dWEN,
  input  logic             wb_halt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             exmem_flush,
  output logic             memwb_en,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // state | meaning
  // RUN   | normal issue
  // DWAIT | data access outstanding, pipeline frozen upstream of MEM/WB
  // HALT  | terminal, left only through reset
  typedef enum logic [1:0] {RUN, DWAIT, HALT} state_t;

  state_t state, state_nxt;
  logic   mem_stall, load_use, stall_evt, flush_evt;

  assign mem_stall = (mem_dREN | mem_dWEN) & ~dhit;
  assign load_use  = ex_dREN & ex_RegWr & (ex_wsel != 5'd0) &
                     ((ex_wsel == id_rs) | (id_uses_rt & (ex_wsel == id_rt)));

  always_comb begin
    state_nxt = state;
    if (state != HALT) begin
      if (wb_halt)
        state_nxt = HALT;
      else if (state == RUN && mem_stall)
        state_nxt = DWAIT;
      else if (state == DWAIT && dhit)
        state_nxt = RUN;
    end
  end

  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    ifid_flush  = 1'b0;
    idex_en     = 1'b0;
    idex_flush  = 1'b0;
    exmem_en    = 1'b0;
    exmem_flush = 1'b0;
    memwb_en    = 1'b0;
    halted      = 1'b0;
    flush_evt   = 1'b0;
    if (!nRST) begin
      halted = 1'b0;
    end else if (state == HALT || wb_halt) begin
      halted = 1'b1;
    end else if (mem_stall) begin
      // bubble into MEM/WB while the access is outstanding
      memwb_en    = 1'b1;
      exmem_flush = 1'b1;
    end else if (ex_redirect) begin
      pc_en      = 1'b1;
      ifid_en    = 1'b1;
      idex_en    = 1'b1;
      exmem_en   = 1'b1;
      memwb_en   = 1'b1;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      flush_evt  = 1'b1;
    end else if (load_use) begin
      idex_en    = 1'b1;
      idex_flush = 1'b1;
      exmem_en   = 1'b1;
      memwb_en   = 1'b1;
    end else if (!ihit) begin
      ifid_en    = 1'b1;
      ifid_flush = 1'b1;
      idex_en    = 1'b1;
      exmem_en   = 1'b1;
      memwb_en   = 1'b1;
    end else begin
      pc_en    = 1'b1;
      ifid_en  = 1'b1;
      idex_en  = 1'b1;
      exmem_en = 1'b1;
      memwb_en = 1'b1;
    end
  end

  assign stall_evt = ~pc_en & ~halted;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= RUN;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (stall_evt && stall_cnt != {CNT_W{1'b1}})
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_evt && flush_cnt != {CNT_W{1'b1}})
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit; a second CNT_W=2 instance covers saturation.
module tb_hazard_unit;

  logic       CLK = 1'b0;
  logic       nRST;
  logic       ihit, dhit, id_uses_rt, ex_dREN, ex_RegWr, ex_redirect;
  logic       mem_dREN, mem_dWEN, wb_halt;
  logic [4:0] id_rs, id_rt, ex_wsel;

  logic        pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
  logic        exmem_en, exmem_flush, memwb_en, halted;
  logic [15:0] stall_cnt, flush_cnt;
  logic [8:0]  ctl_s;
  logic [1:0]  stall_cnt_s, flush_cnt_s;

  int errors = 0;
  int checks = 0;

  // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en, halted}
  logic [8:0] ctl;
  assign ctl = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
                exmem_en, exmem_flush, memwb_en, halted};

  localparam logic [8:0] V_RUN    = 9'b110101010;
  localparam logic [8:0] V_MEM    = 9'b000000110;
  localparam logic [8:0] V_REDIR  = 9'b111111010;
  localparam logic [8:0] V_LU     = 9'b000011010;
  localparam logic [8:0] M_LU     = 9'b111011111;
  localparam logic [8:0] V_IMISS  = 9'b001101010;
  localparam logic [8:0] M_IMISS  = 9'b101111111;
  localparam logic [8:0] V_HALT   = 9'b000000001;
  localparam logic [8:0] V_ZERO   = 9'b000000000;

  always #5 CLK = ~CLK;

  hazard_unit #(.CNT_W(16)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .ex_dREN(ex_dREN), .ex_RegWr(ex_RegWr), .ex_wsel(ex_wsel),
    .ex_redirect(ex_redirect), .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN), .wb_halt(wb_halt),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en),
    .idex_flush(idex_flush), .exmem_en(exmem_en), .exmem_flush(exmem_flush),
    .memwb_en(memwb_en), .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  hazard_unit #(.CNT_W(2)) dut_s (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .ex_dREN(ex_dREN), .ex_RegWr(ex_RegWr), .ex_wsel(ex_wsel),
    .ex_redirect(ex_redirect), .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN), .wb_halt(wb_halt),
    .pc_en(ctl_s[8]), .ifid_en(ctl_s[7]), .ifid_flush(ctl_s[6]), .idex_en(ctl_s[5]),
    .idex_flush(ctl_s[4]), .exmem_en(ctl_s[3]), .exmem_flush(ctl_s[2]),
    .memwb_en(ctl_s[1]), .halted(ctl_s[0]), .stall_cnt(stall_cnt_s), .flush_cnt(flush_cnt_s)
  );

  task automatic idle_inputs();
    ihit = 1'b1; dhit = 1'b0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
    ex_dREN = 1'b0; ex_RegWr = 1'b0; ex_wsel = 5'd0; ex_redirect = 1'b0;
    mem_dREN = 1'b0; mem_dWEN = 1'b0; wb_halt = 1'b0;
  endtask

  // advance one edge; inputs are then changed 1 time unit after it
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    idle_inputs();
    repeat (2) @(posedge CLK);
    #2 nRST = 1'b1;
    step();
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    idle_inputs();
    wb_halt = 1'b1;
    #3;
    checks++;
    if (ctl !== V_ZERO) begin errors++; $display("FAIL reset_ctl: got %b want %b", ctl, V_ZERO); end
    wb_halt = 1'b0;
    do_reset();
    #1;
    checks++;
    if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", stall_cnt, flush_cnt);
    end
    checks++;
    if (ctl !== V_RUN) begin errors++; $display("FAIL reset_run: got %b want %b", ctl, V_RUN); end
  endtask

  task automatic test_load_use();
    do_reset();
    ex_dREN = 1'b1; ex_RegWr = 1'b1; ex_wsel = 5'd5; id_rs = 5'd5;
    #1;
    checks++;
    if ((ctl & M_LU) !== V_LU) begin errors++; $display("FAIL load_use_ctl: got %b want %b", ctl, V_LU); end
    step();
    ex_dREN = 1'b0; ex_RegWr = 1'b0; ex_wsel = 5'd0;
    #1;
    checks++;
    if (ctl !== V_RUN) begin errors++; $display("FAIL load_use_after: got %b want %b", ctl, V_RUN); end
    checks++;
    if (stall_cnt !== 16'd1) begin errors++; $display("FAIL load_use_cnt: got %0d want 1", stall_cnt); end
  endtask

  task automatic test_rt_zero();
    do_reset();
    ex_dREN = 1'b1; ex_RegWr = 1'b1; ex_wsel = 5'd0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b1;
    #1;
    checks++;
    if (ctl !== V_RUN) begin errors++; $display("FAIL reg0_no_stall: got %b want %b", ctl, V_RUN); end
    ex_wsel = 5'd7; id_rs = 5'd3; id_rt = 5'd7; id_uses_rt = 1'b0;
    #1;
    checks++;
    if (ctl !== V_RUN) begin errors++; $display("FAIL rt_unused: got %b want %b", ctl, V_RUN); end
    id_uses_rt = 1'b1;
    #1;
    checks++;
    if ((ctl & M_LU) !== V_LU) begin errors++; $display("FAIL rt_used: got %b want %b", ctl, V_LU); end
    ex_RegWr = 1'b0;
    #1;
    checks++;
    if (ctl !== V_RUN) begin errors++; $display("FAIL no_regwr: got %b want %b", ctl, V_RUN); end
  endtask

  task automatic test_data_wait();
    do_reset();
    mem_dREN = 1'b1; dhit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (ctl !== V_MEM) begin errors++; $display("FAIL dwait_ctl[%0d]: got %b want %b", i, ctl, V_MEM); end
      step();
    end
    dhit = 1'b1;
    #1;
    checks++;
    if (ctl !== V_RUN) begin errors++; $display("FAIL dwait_release: got %b want %b", ctl, V_RUN); end
    step();
    idle_inputs();
    #1;
    checks++;
    if (stall_cnt !== 16'd3) begin errors++; $display("FAIL dwait_cnt: got %0d want 3", stall_cnt); end
    mem_dWEN = 1'b1; dhit = 1'b1;
    #1;
    checks++;
    if (ctl !== V_RUN) begin errors++; $display("FAIL store_hit_same_cycle: got %b want %b", ctl, V_RUN); end
  endtask

  task automatic test_redirect();
    do_reset();
    ex_redirect = 1'b1; ihit = 1'b0;
    ex_dREN = 1'b1; ex_RegWr = 1'b1; ex_wsel = 5'd4; id_rs = 5'd4;
    #1;
    checks++;
    if (ctl !== V_REDIR) begin errors++; $display("FAIL redirect_imiss: got %b want %b", ctl, V_REDIR); end
    step();
    idle_inputs();
    ihit = 1'b0;
    #1;
    checks++;
    if (flush_cnt !== 16'd1 || stall_cnt !== 16'd0) begin
      errors++; $display("FAIL redirect_cnt: got %0d/%0d want 1/0", flush_cnt, stall_cnt);
    end
    checks++;
    if ((ctl & M_IMISS) !== V_IMISS) begin errors++; $display("FAIL imiss_ctl: got %b want %b", ctl, V_IMISS); end
    step();
    ihit = 1'b1; ex_redirect = 1'b1; mem_dWEN = 1'b1; dhit = 1'b0;
    #1;
    checks++;
    if (ctl !== V_MEM) begin errors++; $display("FAIL redirect_vs_dmiss: got %b want %b", ctl, V_MEM); end
    step();
    idle_inputs();
    #1;
    checks++;
    if (flush_cnt !== 16'd1 || stall_cnt !== 16'd2) begin
      errors++; $display("FAIL redirect_dmiss_cnt: got %0d/%0d want 1/2", flush_cnt, stall_cnt);
    end
  endtask

  task automatic test_halt();
    do_reset();
    ex_redirect = 1'b1;
    step();
    idle_inputs();
    wb_halt = 1'b1; ex_redirect = 1'b1;
    #1;
    checks++;
    if (ctl !== V_HALT) begin errors++; $display("FAIL halt_same_cycle: got %b want %b", ctl, V_HALT); end
    step();
    wb_halt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (ctl !== V_HALT) begin errors++; $display("FAIL halt_hold[%0d]: got %b want %b", i, ctl, V_HALT); end
      step();
    end
    ihit = 1'b0;
    step();
    #1;
    checks++;
    if (flush_cnt !== 16'd1 || stall_cnt !== 16'd0) begin
      errors++; $display("FAIL halt_frozen: got %0d/%0d want 1/0", flush_cnt, stall_cnt);
    end
    // reset out of HALT
    nRST = 1'b0;
    #1;
    checks++;
    if (ctl !== V_ZERO) begin errors++; $display("FAIL halt_reset_ctl: got %b want %b", ctl, V_ZERO); end
    do_reset();
    #1;
    checks++;
    if (ctl !== V_RUN) begin errors++; $display("FAIL halt_reset_run: got %b want %b", ctl, V_RUN); end
  endtask

  task automatic test_reset_dwait();
    do_reset();
    mem_dREN = 1'b1; dhit = 1'b0;
    step();
    step();
    #2 nRST = 1'b0;
    #1;
    checks++;
    if (ctl !== V_ZERO) begin errors++; $display("FAIL dwait_reset_ctl: got %b want %b", ctl, V_ZERO); end
    checks++;
    if (stall_cnt !== 16'd0) begin errors++; $display("FAIL dwait_reset_cnt: got %0d want 0", stall_cnt); end
    do_reset();
    #1;
    checks++;
    if (ctl !== V_RUN || stall_cnt !== 16'd0) begin
      errors++; $display("FAIL dwait_reset_release: got %b/%0d want %b/0", ctl, stall_cnt, V_RUN);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    ihit = 1'b0;
    repeat (5) step();
    #1;
    checks++;
    if (stall_cnt_s !== 2'd3) begin errors++; $display("FAIL stall_sat: got %0d want 3", stall_cnt_s); end
    checks++;
    if (stall_cnt !== 16'd5) begin errors++; $display("FAIL stall_wide: got %0d want 5", stall_cnt); end
    ihit = 1'b1; ex_redirect = 1'b1;
    repeat (5) step();
    #1;
    checks++;
    if (flush_cnt_s !== 2'd3 || flush_cnt !== 16'd5) begin
      errors++; $display("FAIL flush_sat: got %0d/%0d want 3/5", flush_cnt_s, flush_cnt);
    end
    idle_inputs();
  endtask

  initial begin
    nRST = 1'b0;
    idle_inputs();
    test_reset();
    test_load_use();
    test_rt_zero();
    test_data_wait();
    test_redirect();
    test_halt();
    test_reset_dwait();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
